pc_if_id_stage: RTL and testbench

PC_IF_ID_STAGE -- requirements
Module: pc_if_id_stage

---
 rtl/pc_if_id_stage.sv | 127 ++++++++++++
 tb/tb_pc_if_id_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_if_id_stage.sv
// Program counter and IF/ID pipeline register with stall, redirect and stall-timeout tracking.
// Defining PC_IF_ID_STALL_STATS_EN adds the stall_count and flush_count statistic outputs.
module pc_if_id_stage (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic        prevent_update_pc,
  input  logic        prevent_update_reg_IF_ID,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_mem,
  output logic [31:0] pc,
  output logic [31:0] pc_IF_ID,
  output logic [31:0] instr_IF_ID,
  output logic        valid_IF_ID,
  output logic        stall_timeout
`ifdef PC_IF_ID_STALL_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [7:0]  HOLD_MAX  = 8'd255;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pc_id_nxt;
  logic [31:0] instr_id_nxt;
  logic        valid_id_nxt;
  logic [7:0]  hold_cnt, hold_cnt_nxt;
  logic        timeout_nxt;
  logic        stall_any;
  logic        in_hold;

  assign stall_any = prevent_update_pc | prevent_update_reg_IF_ID;
  assign in_hold   = (state == ST_HOLD);

  // Next-state and next-register values; enable gating lives in the register process.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    pc_id_nxt    = pc_IF_ID;
    instr_id_nxt = instr_IF_ID;
    valid_id_nxt = valid_IF_ID;

    if (redirect_valid) begin
      // A redirect flushes IF/ID to a NOP bubble but keeps pc_IF_ID as it was.
      pc_nxt       = {redirect_target[31:2], 2'b00};
      instr_id_nxt = NOP_INSTR;
      valid_id_nxt = 1'b0;
      state_nxt    = ST_RUN;
    end else begin
      unique case (state)
        ST_BOOT: begin
          pc_nxt       = pc + PC_STEP;
          instr_id_nxt = NOP_INSTR;
          valid_id_nxt = 1'b0;
          state_nxt    = ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          // Each stall input gates only its own register; HOLD differs from RUN only in timing.
          if (!prevent_update_pc) pc_nxt = pc + PC_STEP;
          if (!prevent_update_reg_IF_ID) begin
            pc_id_nxt    = pc;
            instr_id_nxt = instr_mem;
            valid_id_nxt = 1'b1;
          end
          state_nxt = stall_any ? ST_HOLD : ST_RUN;
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  // Consecutive-HOLD counter saturates; the timeout flag is sticky until reset.
  always_comb begin
    hold_cnt_nxt = 8'd0;
    if (in_hold) hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
    timeout_nxt = stall_timeout | (in_hold && (hold_cnt >= HOLD_MAX - 8'd1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a plain flop with a defined reset value; there is no memory array to leave unreset.
    if (!arst_n) begin
      state         <= ST_BOOT;
      pc            <= 32'd0;
      pc_IF_ID      <= 32'd0;
      instr_IF_ID   <= NOP_INSTR;
      valid_IF_ID   <= 1'b0;
      hold_cnt      <= 8'd0;
      stall_timeout <= 1'b0;
    end else if (enable) begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      pc_IF_ID      <= pc_id_nxt;
      instr_IF_ID   <= instr_id_nxt;
      valid_IF_ID   <= valid_id_nxt;
      hold_cnt      <= hold_cnt_nxt;
      stall_timeout <= timeout_nxt;
    end
  end

`ifdef PC_IF_ID_STALL_STATS_EN
  // Statistics wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else if (enable) begin
      if (in_hold)        stall_count <= stall_count + 32'd1;
      if (redirect_valid) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_if_id_stage.sv
// Self-checking bench for pc_if_id_stage: directed scenarios followed by random stimulus
// compared against a behavioural model of the fetch stage.
module tb_pc_if_id_stage;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] SALT      = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        prevent_update_pc;
  logic        prevent_update_reg_IF_ID;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_mem;
  logic [31:0] pc;
  logic [31:0] pc_IF_ID;
  logic [31:0] instr_IF_ID;
  logic        valid_IF_ID;
  logic        stall_timeout;
`ifdef PC_IF_ID_STALL_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  pc_if_id_stage dut (
    .clk                      (clk),
    .arst_n                   (arst_n),
    .enable                   (enable),
    .prevent_update_pc        (prevent_update_pc),
    .prevent_update_reg_IF_ID (prevent_update_reg_IF_ID),
    .redirect_valid           (redirect_valid),
    .redirect_target          (redirect_target),
    .instr_mem                (instr_mem),
    .pc                       (pc),
    .pc_IF_ID                 (pc_IF_ID),
    .instr_IF_ID              (instr_IF_ID),
    .valid_IF_ID              (valid_IF_ID),
    .stall_timeout            (stall_timeout)
`ifdef PC_IF_ID_STALL_STATS_EN
    ,
    .stall_count              (stall_count),
    .flush_count              (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: what the stage should hold after each edge.
  logic [31:0] m_pc, m_pc_id, m_instr;
  logic        m_valid, m_timeout;
  bit          m_fresh;      // the first enabled cycle after reset only inserts a bubble
  bit          m_stalled;    // the previous enabled cycle asked for a stall
  int          m_hold_run;   // consecutive stalled cycles, unbounded
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model(input logic r_n, input logic en, input logic ppc, input logic preg,
                       input logic rv, input logic [31:0] tgt, input logic [31:0] im);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (!r_n) begin
      m_pc = 0; m_pc_id = 0; m_instr = NOP_INSTR; m_valid = 0; m_timeout = 0;
      m_fresh = 1; m_stalled = 0; m_hold_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else if (en) begin
      if (m_stalled) begin
        m_hold_run++;
        m_stall_cnt++;
      end else begin
        m_hold_run = 0;
      end
      if (m_hold_run >= 255) m_timeout = 1;
      if (rv) begin
        m_pc = tgt & ~32'd3; m_instr = NOP_INSTR; m_valid = 0;
        m_fresh = 0; m_stalled = 0; m_flush_cnt++;
      end else if (m_fresh) begin
        m_pc = old_pc + 4; m_instr = NOP_INSTR; m_valid = 0; m_fresh = 0;
      end else begin
        if (!ppc) m_pc = old_pc + 4;
        if (!preg) begin m_pc_id = old_pc; m_instr = im; m_valid = 1; end
        m_stalled = ppc | preg;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output with the model.
  task automatic step(input logic r_n, input logic en, input logic ppc, input logic preg,
                      input logic rv, input logic [31:0] tgt);
    arst_n = r_n; enable = en; prevent_update_pc = ppc; prevent_update_reg_IF_ID = preg;
    redirect_valid = rv; redirect_target = tgt;
    instr_mem = m_pc ^ SALT;
    @(posedge clk);
    #1;
    cyc++;
    model(r_n, en, ppc, preg, rv, tgt, m_pc ^ SALT);
    check("pc", pc, m_pc);
    check("pc_IF_ID", pc_IF_ID, m_pc_id);
    check("instr_IF_ID", instr_IF_ID, m_instr);
    check("valid_IF_ID", {31'd0, valid_IF_ID}, {31'd0, m_valid});
    check("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_timeout});
`ifdef PC_IF_ID_STALL_STATS_EN
    check("stall_count", stall_count, m_stall_cnt);
    check("flush_count", flush_count, m_flush_cnt);
`endif
  endtask

  logic [31:0] snap_pc, snap_pc_id, snap_instr;

  initial begin
    arst_n = 0; enable = 1; prevent_update_pc = 0; prevent_update_reg_IF_ID = 0;
    redirect_valid = 0; redirect_target = 0; instr_mem = 0;
    m_pc = 0; m_pc_id = 0; m_instr = NOP_INSTR; m_valid = 0; m_timeout = 0;
    m_fresh = 1; m_stalled = 0; m_hold_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;

    // Reset, then free run.
    step(0, 1, 1, 1, 1, 32'h1234);
    step(0, 1, 0, 0, 0, 0);
    check("reset_pc", pc, 32'd0);
    check("reset_instr", instr_IF_ID, NOP_INSTR);
    check("reset_valid", {31'd0, valid_IF_ID}, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    check("boot_pc", pc, 32'd4);
    check("boot_valid", {31'd0, valid_IF_ID}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0, 0, 0);
      check("run_pc_id", pc_IF_ID, pc - 32'd4);
      check("run_instr", instr_IF_ID, (pc - 32'd4) ^ SALT);
      check("run_valid", {31'd0, valid_IF_ID}, 32'd1);
    end
    check("run_pc_20", pc, 32'h20);

    // Both stalls for three cycles at pc=0x20.
    snap_pc_id = pc_IF_ID; snap_instr = instr_IF_ID;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, 0, 0);
      check("stall_pc", pc, 32'h20);
      check("stall_pc_id", pc_IF_ID, snap_pc_id);
      check("stall_instr", instr_IF_ID, snap_instr);
    end
    step(1, 1, 0, 0, 0, 0);
    check("release_pc", pc, 32'h24);
    check("release_pc_id", pc_IF_ID, 32'h20);

    // Redirect while stalled.
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h103);
    check("redir_pc", pc, 32'h100);
    check("redir_instr", instr_IF_ID, NOP_INSTR);
    check("redir_valid", {31'd0, valid_IF_ID}, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    check("redir_run_pc", pc, 32'h104);
    check("redir_run_pc_id", pc_IF_ID, 32'h100);

    // Wrap-around at the top of the address space.
    step(1, 1, 0, 0, 1, 32'hFFFF_FFFE);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Long stall with an enable=0 gap that must not advance the HOLD counter.
    for (int i = 0; i < 255; i++) step(1, 1, 1, 1, 0, 0);
    check("timeout_early", {31'd0, stall_timeout}, 32'd0);
    snap_pc = pc; snap_pc_id = pc_IF_ID; snap_instr = instr_IF_ID;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 1, 1, 32'h40);
      check("frozen_pc", pc, snap_pc);
      check("frozen_pc_id", pc_IF_ID, snap_pc_id);
      check("frozen_instr", instr_IF_ID, snap_instr);
    end
    check("frozen_timeout", {31'd0, stall_timeout}, 32'd0);
    step(1, 1, 1, 1, 0, 0);
    check("timeout_set", {31'd0, stall_timeout}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    check("timeout_sticky", {31'd0, stall_timeout}, 32'd1);
    step(0, 1, 1, 1, 1, 32'h80);
    check("timeout_cleared", {31'd0, stall_timeout}, 32'd0);
    check("reset_over_redirect", pc, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r_n, en, ppc, preg, rv;
      r_n  = ($urandom_range(99) >= 2);
      en   = ($urandom_range(99) >= 10);
      ppc  = ($urandom_range(99) < 30);
      preg = ($urandom_range(99) < 30);
      rv   = ($urandom_range(99) < 8);
      step(r_n, en, ppc, preg, rv, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end

endmodule
